present80_dec: RTL and testbench
================================

# present80_dec

Iterative PRESENT-80 decryption core: accepts a 64-bit ciphertext and an 80-bit user key, and returns the 64-bit plaintext 63 cycles later.
- Runs the forward key schedule 31 times to reach the final round key, then unrolls the cipher one round per cycle using the inverse S-box layer, the inverse bit permutation and the reverse key schedule.
- It is the receive-side counterpart of the encryption datapath and uses the same 4-bit PRESENT S-box table in its key schedule.

## Interface
Parameters:
- ROUNDS, 31, number of cipher rounds; fixed at 31 for PRESENT-80, not for variation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  request; ciphertext and key presented
- in_ready  output  1  high only in IDLE; a transfer happens when in_valid && in_ready
- ct_in  input  64  ciphertext; bit 63 is MSB
- key_in  input  80  user key K[79:0]
- out_valid  output  1  one-cycle pulse; pt_out is valid in this cycle
- pt_out  output  64  plaintext; held until the next result is written
- busy  output  1  high in KEYEXP, DEC and FINAL

## Operation
- Internal registers:
  - state[63:0]
  - key[79:0]
  - rc[4:0], the round counter
  - FSM: IDLE, KEYEXP, DEC, FINAL
- Inverse S-box, indexed 0..F: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  - Applied to all 16 nibbles of state.
- Forward S-box, indexed 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - Used only on key[79:76] during KEYEXP.
- Inverse permutation: state bit j moves to bit (4*j mod 63) for j<63; bit 63 stays at 63.
- Forward key update with counter i, applied in this order:
  - rotate key left 61
  - key[79:76] = S(key[79:76])
  - key[19:15] ^= i
- Reverse key update with counter r, applied in this order:
  - key[19:15] ^= r
  - key[79:76] = S^-1(key[79:76])
  - rotate key right 61
- Round key is always key[79:16].
- IDLE: on transfer, state<=ct_in, key<=key_in, rc<=1, go to KEYEXP.
- KEYEXP: each cycle, forward key update with rc, then rc<=rc+1.
  - When rc==31, key becomes K32; set rc<=31 and go to DEC.
- DEC: each cycle, state <= invS(invP(state ^ key[79:16])), and key takes the reverse update with rc.
  - rc decrements each cycle.
  - When rc==1, key becomes K1; go to FINAL.
- FINAL: pt_out <= state ^ key[79:16], out_valid<=1, go to IDLE.
- Arithmetic: rc is 5 bits and never wraps; the valid range in KEYEXP and DEC is 1..31.
- in_valid while busy is ignored. No queuing; the inputs are not sampled.
- key_in and ct_in are sampled only at the transfer cycle; later changes have no effect.

## Timing
- Reset values, applied asynchronously:
  - FSM=IDLE
  - in_ready=1, busy=0, out_valid=0
  - pt_out=0, state=0, key=0, rc=0
- Transfer at edge T:
  - KEYEXP occupies edges T+1..T+31.
  - DEC occupies edges T+32..T+62.
  - FINAL at edge T+63 writes pt_out.
  - out_valid is high in the cycle after edge T+63.
- in_ready is high again in that same out_valid cycle.
  - A new transfer in that cycle is legal, giving back-to-back throughput of one block per 64 cycles.
- Reset asserted mid-operation aborts immediately.
  - No out_valid is produced.
  - The block returns to IDLE with in_ready=1 after rst_n deasserts.
- in_ready and busy are registered-state decodes: no combinational path from in_valid.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-KEYEXP, then release.
  - Required response: out_valid stays 0, in_ready=1, pt_out=0, and a subsequent decrypt completes correctly.
- Vector 1:
  - Stimulus: ct=5579C1387B228445, key=0.
  - Required response: pt=0000000000000000, with out_valid exactly 64 cycles after the transfer cycle.
- Vector 2:
  - Stimulus: ct=E72C46C0F5945049, key=FFFFFFFFFFFFFFFFFFFF.
  - Required response: pt=0000000000000000.
- Vectors 3 and 4:
  - Stimulus: ct=A112FFC72F68417B with key=0, and ct=3333DCD3213210D2 with key=all-ones.
  - Required response: pt=FFFFFFFFFFFFFFFF in both cases.
- Busy protection:
  - Stimulus: pulse in_valid with different ct and key at cycles 5, 30 and 60 of a decrypt.
  - Required response: in_ready=0 at those cycles, and the result still matches the original request.
- Back-to-back:
  - Stimulus: issue Vector 2 in the out_valid cycle of Vector 1.
  - Required response: both results are correct, 64 cycles apart; then run 1000 random key/plaintext pairs through a reference encrypt model.

Source files
------------

// File: rtl/present80_dec_if.sv
// Request/response bundle for the PRESENT-80 decryption core.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// in_ready is high only while the core is idle, so in_valid seen while busy is
// dropped. The result side has no backpressure: out_valid is a single-cycle
// pulse and pt_out keeps the last plaintext until the next one is written.
interface present80_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ct_in;
  logic [79:0] key_in;
  logic        out_valid;
  logic [63:0] pt_out;
  logic        busy;

  modport master (
    output in_valid, ct_in, key_in,
    input  in_ready, out_valid, pt_out, busy
  );

  modport slave (
    input  in_valid, ct_in, key_in,
    output in_ready, out_valid, pt_out, busy
  );
endinterface

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryption core. The key register is first walked
// forward to the last round key, then the cipher is unwound one round per
// cycle while the key schedule runs backwards alongside it.
module present80_dec #(
  parameter int ROUNDS = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  present80_dec_if.slave bus
);

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, FINAL} fsm_t;

  fsm_t        fsm;
  logic [63:0] state;
  logic [79:0] key;
  logic [4:0]  rc;
  logic [63:0] pt_q;
  logic        out_valid_q;

  logic [79:0] key_fwd;
  logic [79:0] key_rev;
  logic [63:0] state_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  // Inverse bit permutation: bit j lands on 4*j mod 63, bit 63 is fixed.
  function automatic logic [63:0] inv_perm(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int j = 0; j < 63; j++) begin
      o[(4 * j) % 63] = x[j];
    end
    o[63] = x[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_sub(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = inv_sbox(x[4*n +: 4]);
    end
    return o;
  endfunction

  // Forward key step: rotate left 61, S-box top nibble, mix in the counter.
  always_comb begin
    key_fwd          = {key[18:0], key[79:19]};
    key_fwd[79:76]   = sbox(key_fwd[79:76]);
    key_fwd[19:15]   = key_fwd[19:15] ^ rc;
  end

  // Reverse key step: undo the forward step in exactly the opposite order.
  always_comb begin
    key_rev          = key;
    key_rev[19:15]   = key_rev[19:15] ^ rc;
    key_rev[79:76]   = inv_sbox(key_rev[79:76]);
    key_rev          = {key_rev[60:0], key_rev[79:61]};
  end

  // One inverse round: strip the round key, undo the permutation, undo the S-layer.
  always_comb begin
    state_nxt = inv_sub(inv_perm(state ^ key[79:16]));
  end

  // Control FSM and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state       <= '0;
      key         <= '0;
      rc          <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state <= bus.ct_in;
            key   <= bus.key_in;
            rc    <= 5'd1;
            fsm   <= KEYEXP;
          end
        end
        KEYEXP: begin
          key <= key_fwd;
          if (rc == LAST_RC) begin
            rc  <= LAST_RC;
            fsm <= DEC;
          end else begin
            rc <= rc + 5'd1;
          end
        end
        DEC: begin
          state <= state_nxt;
          key   <= key_rev;
          rc    <= rc - 5'd1;
          if (rc == 5'd1) begin
            fsm <= FINAL;
          end
        end
        FINAL: begin
          pt_q        <= state ^ key[79:16];
          out_valid_q <= 1'b1;
          fsm         <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (fsm == IDLE);
  assign bus.busy      = (fsm != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.pt_out    = pt_q;

endmodule

// File: tb/tb_present80_dec.sv
// Bench for present80_dec: known-answer vectors, busy protection, reset abort,
// back-to-back issue and random blocks checked against an encryption model.
module tb_present80_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  present80_dec_if bus();

  present80_dec #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Hard time limit in case anything stalls outside the bounded waits
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [63:0] ct;
    logic [79:0] key;
    logic [63:0] pt;
  } vec_t;

  vec_t        vecs [4];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] SBOX_TAB = 64'hC56B90AD3EF84712;

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    int idx;
    idx = (15 - int'(x)) * 4;
    return SBOX_TAB[idx +: 4];
  endfunction

  // Reference PRESENT-80 encryption
  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_sbox(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: transfer one block, optionally poke in_valid while busy, and
  // return in the out_valid cycle so the next call can issue back-to-back.
  task automatic run_one(input logic [63:0] ct, input logic [79:0] key,
                         input logic [63:0] pt, input bit inject, input string tag);
    int n;
    logic [63:0] exp;
    exp_q.push_back(pt);
    check({tag, " in_ready at issue"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.ct_in    = ct;
    bus.key_in   = key;
    tick();
    bus.in_valid = 1'b0;
    bus.ct_in    = {$urandom, $urandom};
    bus.key_in   = {$urandom, $urandom, 16'($urandom)};
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
      if (inject && (n == 5 || n == 30 || n == 60)) begin
        check($sformatf("%s in_ready busy c%0d", tag, n), 64'(bus.in_ready), 64'd0);
        check($sformatf("%s busy c%0d", tag, n), 64'(bus.busy), 64'd1);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd63);
    exp = exp_q.pop_front();
    check({tag, " pt_out"}, bus.pt_out, exp);
  endtask

  // Stimulus and scoreboard
  initial begin
    logic seen_ov;
    bus.in_valid = 1'b0;
    bus.ct_in    = '0;
    bus.key_in   = '0;

    vecs[0] = '{ct: 64'h5579C1387B228445, key: 80'h0,                    pt: 64'h0};
    vecs[1] = '{ct: 64'hE72C46C0F5945049, key: 80'hFFFFFFFFFFFFFFFFFFFF, pt: 64'h0};
    vecs[2] = '{ct: 64'hA112FFC72F68417B, key: 80'h0,                    pt: 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{ct: 64'h3333DCD3213210D2, key: 80'hFFFFFFFFFFFFFFFFFFFF, pt: 64'hFFFFFFFFFFFFFFFF};

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset pt_out", bus.pt_out, 64'd0);
    rst_n = 1'b1;
    tick();

    // Known answers, issued back-to-back
    for (int i = 0; i < 4; i++) begin
      run_one(vecs[i].ct, vecs[i].key, vecs[i].pt, 1'b0, $sformatf("vec%0d", i + 1));
    end
    tick();
    check("out_valid pulse width", 64'(bus.out_valid), 64'd0);
    repeat (5) tick();
    check("pt_out held", bus.pt_out, 64'hFFFFFFFFFFFFFFFF);
    check("idle in_ready", 64'(bus.in_ready), 64'd1);

    // Busy protection
    run_one(vecs[1].ct, vecs[1].key, vecs[1].pt, 1'b1, "busyprot");
    tick();

    // Reset abort in the middle of key expansion
    bus.in_valid = 1'b1;
    bus.ct_in    = vecs[2].ct;
    bus.key_in   = vecs[2].key;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    check("abort busy before reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort pt_out", bus.pt_out, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus.out_valid) seen_ov = 1'b1;
    end
    check("abort no out_valid", 64'(seen_ov), 64'd0);
    check("abort idle in_ready", 64'(bus.in_ready), 64'd1);
    run_one(vecs[3].ct, vecs[3].key, vecs[3].pt, 1'b0, "after_abort");

    // Random blocks against the encryption model
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] pt;
      logic [79:0] key;
      pt  = {$urandom, $urandom};
      key = {$urandom, $urandom, 16'($urandom)};
      run_one(present_enc(pt, key), key, pt, 1'b0, $sformatf("rand%0d", i));
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
